wb_arbiter_2to1: RTL and testbench
==================================

Name: wb_arbiter_2to1

Overview:
- Two-master, one-slave Wishbone (classic, single-transfer) arbiter.
- Shares the single Controller memory port between a core instruction-fetch master (m0) and a data master (m1).
- Used when a dual-port core is built without ENABLE_SECOND_MEMORY.
- Round-robin fairness per transfer, plus a bus-timeout watchdog so a missing ack cannot hang the core.

Parameters:
- ADDR_WIDTH, 32, address width of masters and slave.
- DATA_WIDTH, 32, data width of masters and slave.
- TIMEOUT_CYCLES, 1024, cycles without ack before a transfer is aborted; 0 disables the watchdog.

Ports:
- clk  input  1  core clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- mN_cyc_i  input  1  master N cycle (N = 0, 1).
- mN_stb_i  input  1  master N strobe.
- mN_we_i  input  1  master N write enable.
- mN_addr_i  input  ADDR_WIDTH  master N address.
- mN_data_i  input  DATA_WIDTH  master N write data.
- mN_data_o  output  DATA_WIDTH  read data to master N.
- mN_ack_o  output  1  transfer complete to master N.
- mN_err_o  output  1  timeout abort to master N.
- s_cyc_o  output  1  slave cycle.
- s_stb_o  output  1  slave strobe.
- s_we_o  output  1  slave write enable.
- s_addr_o  output  ADDR_WIDTH  slave address.
- s_data_o  output  DATA_WIDTH  slave write data.
- s_data_i  input  DATA_WIDTH  slave read data.
- s_ack_i  input  1  slave ack.

Behaviour:
- State machine:
  - States: IDLE, GNT0, GNT1.
  - Registers: state, last_grant (1 bit), timeout counter.
- Reset (rst=1 at clock edge):
  - state=IDLE, last_grant=1 (m0 wins the first tie), counter=0.
  - All outputs are combinationally 0 while in IDLE.
- Request: mN_req = mN_cyc_i & mN_stb_i.
- IDLE:
  - Only m0 requesting: go to GNT0. Only m1 requesting: go to GNT1.
  - Both requesting: grant the master != last_grant.
  - Neither: stay in IDLE.
  - Arbitration costs exactly 1 cycle: request seen in cycle N, slave strobed in cycle N+1.
- GNTn:
  - s_cyc_o, s_stb_o, s_we_o, s_addr_o and s_data_o mirror master n combinationally.
  - Slave signals are driven only while mn_cyc_i & mn_stb_i; otherwise they are 0.
  - mn_ack_o = s_ack_i. The other master's ack and err are 0.
  - m0_data_o = m1_data_o = s_data_i at all times; it is qualified only by ack.
- Completion:
  - On s_ack_i in GNTn: last_grant <= n, state <= IDLE, counter <= 0.
  - Every transfer re-arbitrates, so back-to-back requests from both masters alternate.
- Abort:
  - If mn_cyc_i drops while in GNTn without an ack: state <= IDLE.
  - No ack or err is generated; last_grant <= n.
- Timeout (TIMEOUT_CYCLES > 0):
  - Counter increments each cycle in GNTn without s_ack_i.
  - When the counter equals TIMEOUT_CYCLES-1 and there is no ack: mn_err_o = 1 for that single cycle, s_stb_o/s_cyc_o still asserted that cycle.
  - Next state: IDLE, last_grant <= n, counter <= 0.
  - Ack in the same cycle as expiry: ack wins and err stays 0.
  - Counter width is clog2(TIMEOUT_CYCLES+1); no wrap is possible.
- Reset mid-transfer: state forced to IDLE next edge. An in-flight slave ack is ignored and no master receives ack or err.
- Slave ack while in IDLE (spurious): ignored and not forwarded.
- Invariants:
  - mN_ack_o and mN_err_o are never both high.
  - Never more than one master acked per cycle.

Test Plan:
- Reset, then m0 read addr 0x100, slave ack 1 cycle after stb, data 0xDEADBEEF -> s_stb_o high at cycle 1 after request; m0_ack_o=1 with m0_data_o=0xDEADBEEF; m1_ack_o=0.
- Both masters request continuously after reset, slave acks each stb in 1 cycle -> grant order m0, m1, m0, m1; each transfer takes 2 cycles incl. arbitration.
- m1 write 0x12345678 to 0x2000 while m0 idle -> s_we_o=1, s_addr_o=0x2000, s_data_o=0x12345678; m1_ack_o on s_ack_i.
- TIMEOUT_CYCLES=8, m0 requests, slave never acks -> m0_err_o=1 in the 8th GNT0 cycle only, then IDLE; a pending m1 is granted on the next cycle.
- m1 granted, m1_cyc_i deasserted after 2 cycles, no ack -> IDLE; no err or ack; m0 granted next if requesting.
- rst pulsed during GNT0 with s_ack_i=1 in the same cycle -> no ack forwarded; all outputs 0 next cycle; m0 wins the next simultaneous request.

Source files
------------

// File: rtl/wb_arbiter_2to1.sv
// Two-master / one-slave classic Wishbone arbiter: per-transfer round-robin
// with a watchdog that aborts a transfer the slave never acknowledges.
//
// state | meaning
// IDLE  | no grant, slave port quiet, arbitrating pending requests
// GNT0  | m0 owns the slave port until ack, abort or timeout
// GNT1  | m1 owns the slave port until ack, abort or timeout
module wb_arbiter_2to1 #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_data_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_ack_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_t        state, state_nxt;
  logic          last_grant, last_grant_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic m0_req, m1_req;
  logic granted, sel1, req_sel, cyc_sel, expire, fwd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    m0_req  = m0_cyc_i & m0_stb_i;
    m1_req  = m1_cyc_i & m1_stb_i;
    granted = (state != IDLE);
    sel1    = (state == GNT1);
    req_sel = sel1 ? m1_req : m0_req;
    cyc_sel = sel1 ? m1_cyc_i : m0_cyc_i;
    expire  = (TIMEOUT_CYCLES > 0) && granted && cyc_sel && !s_ack_i && (cnt == CNT_LAST);
    // A reset asserted this cycle suppresses any in-flight ack or err.
    fwd     = granted && !rst;
  end

  always_comb begin
    s_cyc_o  = granted && req_sel;
    s_stb_o  = granted && req_sel;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    if (granted && req_sel) begin
      s_we_o   = sel1 ? m1_we_i   : m0_we_i;
      s_addr_o = sel1 ? m1_addr_i : m0_addr_i;
      s_data_o = sel1 ? m1_data_i : m0_data_i;
    end
    m0_data_o = s_data_i;
    m1_data_o = s_data_i;
    m0_ack_o  = fwd && !sel1 && s_ack_i;
    m1_ack_o  = fwd &&  sel1 && s_ack_i;
    m0_err_o  = fwd && !sel1 && expire;
    m1_err_o  = fwd &&  sel1 && expire;
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (m0_req && (!m1_req || last_grant)) state_nxt = GNT0;
        else if (m1_req)                       state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        if (s_ack_i || !cyc_sel || expire) begin
          state_nxt      = IDLE;
          last_grant_nxt = sel1;
          cnt_nxt        = '0;
        end else if (TIMEOUT_CYCLES > 0) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Directed bench for wb_arbiter_2to1 with an 8-cycle watchdog.
module tb_wb_arbiter_2to1;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_ack_i;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_arbiter_2to1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_outputs(input string tag);
    chk({tag, " s_cyc"}, 64'(s_cyc_o), 64'd0);
    chk({tag, " s_stb"}, 64'(s_stb_o), 64'd0);
    chk({tag, " acks"}, 64'({m0_ack_o, m1_ack_o}), 64'd0);
    chk({tag, " errs"}, 64'({m0_err_o, m1_err_o}), 64'd0);
  endtask

  task automatic clear_inputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = '0; m0_data_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = '0; m1_data_i = '0;
    s_data_i = '0; s_ack_i = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst = 0;
  endtask

  initial begin
    clear_inputs();
    do_reset();

    // reset state, spurious ack in IDLE
    s_ack_i = 1;
    @(negedge clk);
    quiet_outputs("reset/spurious");
    next_cycle();
    s_ack_i = 0;

    // m0 read of 0x100
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h100;
    @(negedge clk);
    chk("m0 rd arb cycle stb", 64'(s_stb_o), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("m0 rd stb", 64'(s_stb_o), 64'd1);
    chk("m0 rd addr", 64'(s_addr_o), 64'h100);
    chk("m0 rd we", 64'(s_we_o), 64'd0);
    s_ack_i = 1; s_data_i = 32'hDEADBEEF;
    #1;
    chk("m0 rd ack", 64'(m0_ack_o), 64'd1);
    chk("m0 rd data", 64'(m0_data_o), 64'hDEADBEEF);
    chk("m0 rd m1_ack", 64'(m1_ack_o), 64'd0);
    next_cycle();
    clear_inputs();

    // back-to-back requests from both masters alternate m0,m1,m0,m1
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'hA0;
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rr%0d arb s_cyc", i), 64'(s_cyc_o), 64'd0);
      next_cycle();
      s_ack_i = 1; s_data_i = 32'h1000 + 32'(i);
      @(negedge clk);
      chk($sformatf("rr%0d m0_ack", i), 64'(m0_ack_o), 64'((i % 2) == 0));
      chk($sformatf("rr%0d m1_ack", i), 64'(m1_ack_o), 64'((i % 2) == 1));
      chk($sformatf("rr%0d addr", i), 64'(s_addr_o), ((i % 2) == 0) ? 64'hA0 : 64'hB0);
      next_cycle();
      s_ack_i = 0;
    end
    clear_inputs();

    // m1 write while m0 idle
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_addr_i = 32'h2000; m1_data_i = 32'h12345678;
    next_cycle();
    @(negedge clk);
    chk("m1 wr we", 64'(s_we_o), 64'd1);
    chk("m1 wr addr", 64'(s_addr_o), 64'h2000);
    chk("m1 wr data", 64'(s_data_o), 64'h12345678);
    chk("m1 wr ack before s_ack", 64'(m1_ack_o), 64'd0);
    s_ack_i = 1;
    #1;
    chk("m1 wr ack", 64'(m1_ack_o), 64'd1);
    chk("m1 wr m0_ack", 64'(m0_ack_o), 64'd0);
    next_cycle();
    clear_inputs();

    // watchdog: m0 never acked, m1 pending behind it
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h400;
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h500;
    next_cycle();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("to gnt%0d m0_err", k), 64'(m0_err_o), 64'(k == 8));
      chk($sformatf("to gnt%0d stb", k), 64'(s_stb_o), 64'd1);
      chk($sformatf("to gnt%0d addr", k), 64'(s_addr_o), 64'h400);
      next_cycle();
    end
    m0_cyc_i = 0; m0_stb_i = 0;
    @(negedge clk);
    quiet_outputs("to idle");
    next_cycle();
    @(negedge clk);
    chk("to m1 granted addr", 64'(s_addr_o), 64'h500);
    s_ack_i = 1;
    #1;
    chk("to m1 ack", 64'(m1_ack_o), 64'd1);
    next_cycle();
    clear_inputs();

    // m1 abandons its cycle without ack
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h600;
    next_cycle();
    next_cycle();
    next_cycle();
    m1_cyc_i = 0; m1_stb_i = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 32'h300;
    @(negedge clk);
    quiet_outputs("abort gnt1");
    next_cycle();
    @(negedge clk);
    quiet_outputs("abort idle");
    next_cycle();
    @(negedge clk);
    chk("abort m0 granted addr", 64'(s_addr_o), 64'h300);

    // reset during GNT0 with an ack in flight
    rst = 1; s_ack_i = 1;
    #1;
    chk("rst ack suppressed", 64'({m0_ack_o, m1_ack_o}), 64'd0);
    next_cycle();
    rst = 0; s_ack_i = 0;
    m1_cyc_i = 1; m1_stb_i = 1; m1_addr_i = 32'h700;
    @(negedge clk);
    quiet_outputs("post rst");
    next_cycle();
    @(negedge clk);
    chk("post rst m0 wins", 64'(s_addr_o), 64'h300);
    chk("post rst stb", 64'(s_stb_o), 64'd1);
    next_cycle();
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
